// File: rtl/mc_control.sv
// Multi-cycle MIPS control unit: Moore FSM that sequences the
// shared datapath and drives every strobe and mux select.
module mc_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       halted
);

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXEC   = 4'd6;
  localparam logic [3:0] RWB    = 4'd7;
  localparam logic [3:0] BRANCH = 4'd8;
  localparam logic [3:0] JUMP   = 4'd9;
  localparam logic [3:0] ADDIEX = 4'd10;
  localparam logic [3:0] ADDIWB = 4'd11;
  localparam logic [3:0] HALT   = 4'd15;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  logic [3:0] state_q;
  logic [3:0] state_d;

  logic pcw_raw;
  logic pcwc_raw;
  logic mrd_raw;
  logic mwr_raw;
  logic irw_raw;
  logic rw_raw;
  logic done_raw;

  always_comb begin
    state_d = state_q;
    if (reset) begin
      state_d = FETCH;
    end else begin
      case (state_q)
        FETCH:  state_d = DECODE;
        DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state_d = MEMADR;
            OP_R:         state_d = EXEC;
            OP_BEQ:       state_d = BRANCH;
            OP_J:         state_d = JUMP;
            OP_ADDI:      state_d = ADDIEX;
            default:      state_d = HALT;
          endcase
        end
        MEMADR: state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
        MEMRD:  state_d = MEMWB;
        EXEC:   state_d = RWB;
        ADDIEX: state_d = ADDIWB;
        MEMWB, MEMWR, RWB,
        BRANCH, JUMP, ADDIWB:
                state_d = FETCH;
        default: state_d = HALT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  always_comb begin
    pcw_raw    = 1'b0;
    pcwc_raw   = 1'b0;
    mrd_raw    = 1'b0;
    mwr_raw    = 1'b0;
    irw_raw    = 1'b0;
    rw_raw     = 1'b0;
    done_raw   = 1'b0;
    pc_source  = 2'b00;
    iord       = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctrl   = 3'b010;
    halted     = 1'b0;
    case (state_q)
      FETCH: begin
        mrd_raw   = 1'b1;
        irw_raw   = 1'b1;
        pcw_raw   = 1'b1;
        alu_src_b = 2'b01;
      end
      // Branch target is precomputed into ALUOut here.
      DECODE: alu_src_b = 2'b11;
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: begin
        mrd_raw = 1'b1;
        iord    = 1'b1;
      end
      MEMWB: begin
        rw_raw     = 1'b1;
        mem_to_reg = 1'b1;
        done_raw   = 1'b1;
      end
      MEMWR: begin
        mwr_raw  = 1'b1;
        iord     = 1'b1;
        done_raw = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        case (funct)
          6'b100010: alu_ctrl = 3'b110;
          6'b100100: alu_ctrl = 3'b000;
          6'b100101: alu_ctrl = 3'b001;
          6'b101010: alu_ctrl = 3'b111;
          default:   alu_ctrl = 3'b010;
        endcase
      end
      RWB: begin
        rw_raw   = 1'b1;
        reg_dst  = 1'b1;
        done_raw = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = 3'b110;
        pcwc_raw  = 1'b1;
        pc_source = 2'b01;
        done_raw  = 1'b1;
      end
      JUMP: begin
        pcw_raw   = 1'b1;
        pc_source = 2'b10;
        done_raw  = 1'b1;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ADDIWB: begin
        rw_raw   = 1'b1;
        done_raw = 1'b1;
      end
      HALT:    halted = 1'b1;
      default: halted = 1'b0;
    endcase
  end

  assign pc_write      = pcw_raw & ~reset;
  assign pc_write_cond = pcwc_raw & ~reset;
  assign mem_read      = mrd_raw & ~reset;
  assign mem_write     = mwr_raw & ~reset;
  assign ir_write      = irw_raw & ~reset;
  assign reg_write     = rw_raw & ~reset;
  assign instr_done    = done_raw & ~reset;
  assign pc_en         = pc_write | (pc_write_cond & zero);
  assign state         = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: walks every instruction class
// and checks states and strobes against hand-computed values.
module tb_mc_control;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_en;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctrl;
  logic [3:0] state;
  logic       instr_done;
  logic       halted;

  int checks = 0;
  int failures = 0;

  mc_control dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .funct(funct), .zero(zero), .pc_en(pc_en),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_ctrl(alu_ctrl), .state(state),
    .instr_done(instr_done), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] strobes();
    return {pc_en, pc_write, pc_write_cond, ir_write,
            mem_read, mem_write, reg_write, instr_done};
  endfunction

  function automatic logic done_model(input logic [3:0] s);
    return s inside {4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd11};
  endfunction

  task automatic step(input string tag, input logic [3:0] s);
    tick();
    chk({tag, "_state"}, state, s);
    chk({tag, "_done"}, instr_done, done_model(s));
  endtask

  logic [5:0] fn_tab [6];
  logic [2:0] al_tab [6];

  initial begin
    fn_tab = '{6'b100000, 6'b100010, 6'b100100,
               6'b100101, 6'b101010, 6'b000000};
    al_tab = '{3'b010, 3'b110, 3'b000,
               3'b001, 3'b111, 3'b010};
    reset = 1'b1;
    opcode = 6'b000000;
    funct = 6'b000000;
    zero = 1'b0;
    tick();
    tick();
    chk("rst_state", state, 0);
    chk("rst_strobes", strobes(), 0);

    // drive into EXEC, then reset for 3 cycles
    reset = 1'b0;
    step("pre_dec", 4'd1);
    step("pre_exec", 4'd6);
    reset = 1'b1;
    #1;
    chk("rst6_strobes", strobes(), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstn_state", state, 0);
      chk("rstn_strobes", strobes(), 0);
    end
    reset = 1'b0;
    #1;
    chk("fetch_strobes",
        {mem_read, ir_write, pc_write, pc_en}, 4'hf);
    chk("fetch_srcb", alu_src_b, 2'b01);

    // lw
    opcode = 6'b100011;
    step("lw1", 4'd1);
    chk("dec_srcb", alu_src_b, 2'b11);
    step("lw2", 4'd2);
    chk("lw_adr", {alu_src_a, alu_src_b}, 3'b110);
    step("lw3", 4'd3);
    chk("lw_rd", {mem_read, iord, mem_write}, 3'b110);
    step("lw4", 4'd4);
    chk("lw_wb", {reg_write, mem_to_reg, reg_dst}, 3'b110);
    step("lw0", 4'd0);

    // sw
    opcode = 6'b101011;
    step("sw1", 4'd1);
    chk("sw1_mw", mem_write, 0);
    step("sw2", 4'd2);
    chk("sw2_mw", mem_write, 0);
    step("sw5", 4'd5);
    chk("sw_wr", {mem_write, iord, reg_write}, 3'b110);
    step("sw0", 4'd0);
    chk("sw0_mw", mem_write, 0);

    // R-type funct sweep
    opcode = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      funct = fn_tab[i];
      step("r1", 4'd1);
      step("r6", 4'd6);
      chk("r_alu", alu_ctrl, al_tab[i]);
      chk("r_srca", {alu_src_a, alu_src_b}, 3'b100);
      step("r7", 4'd7);
      chk("r_wb", {reg_write, reg_dst, mem_to_reg}, 3'b110);
      chk("r7_alu", alu_ctrl, 3'b010);
      step("r0", 4'd0);
    end

    // beq taken / not taken
    opcode = 6'b000100;
    for (int z = 1; z >= 0; z--) begin
      zero = 1'b0;
      step("b1", 4'd1);
      chk("b1_pcen", pc_en, 0);
      step("b8", 4'd8);
      zero = z[0];
      #1;
      chk("beq_pcen", pc_en, z[0]);
      chk("beq_src", pc_source, 2'b01);
      chk("beq_alu", alu_ctrl, 3'b110);
      step("b0", 4'd0);
    end
    zero = 1'b0;

    // j
    opcode = 6'b000010;
    step("j1", 4'd1);
    step("j9", 4'd9);
    chk("j_pc", {pc_en, pc_source}, 3'b110);
    step("j0", 4'd0);

    // addi
    opcode = 6'b001000;
    step("a1", 4'd1);
    step("a10", 4'd10);
    chk("addi_srcb", {alu_src_a, alu_src_b}, 3'b110);
    step("a11", 4'd11);
    chk("addi_wb", {reg_write, reg_dst, mem_to_reg}, 3'b100);
    step("a0", 4'd0);

    // illegal opcode halts until reset
    opcode = 6'b111111;
    step("h1", 4'd1);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("halt_state", state, 15);
      chk("halt_flag", halted, 1);
      chk("halt_strobes", strobes(), 0);
      tick();
    end
    reset = 1'b1;
    tick();
    chk("unhalt_state", state, 0);
    chk("unhalt_flag", halted, 0);
    reset = 1'b0;
    opcode = 6'b000000;
    step("post1", 4'd1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle MIPS control unit sequencing the shared datapath: register file, unified instruction/data RAM, ALU, IR and PC. A Moore state machine steps each instruction through fetch, decode, execute, memory and writeback states, driving every datapath strobe and mux select. It supports lw, sw, R-type (add/sub/and/or/slt), addi, beq and j. An unrecognised opcode halts the core until reset.

## Interface
- No parameters.
- clk  in  1  state register clock, rising edge.
- reset  in  1  reset, synchronous, active-high.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- pc_en  out  1  PC load enable, equal to pc_write | (pc_write_cond & zero).
- pc_write  out  1  unconditional PC write.
- pc_write_cond  out  1  branch PC write.
- pc_source  out  2  PC mux select: 00 ALU result, 01 ALUOut register, 10 jump target.
- iord  out  1  memory address select: 0 PC, 1 ALUOut.
- mem_read  out  1  RAM read.
- mem_write  out  1  RAM write.
- ir_write  out  1  IR load.
- reg_dst  out  1  write address select: 0 rt, 1 rd.
- mem_to_reg  out  1  write data select: 0 ALUOut, 1 MDR.
- reg_write  out  1  register file write.
- alu_src_a  out  1  ALU A select: 0 PC, 1 rs.
- alu_src_b  out  2  ALU B select: 00 rt, 01 constant 1, 10 sign-extended imm, 11 sign-extended imm (branch offset).
- alu_ctrl  out  3  ALU function: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- state  out  4  current state, for debug.
- instr_done  out  1  high in the last cycle of each instruction.
- halted  out  1  high in HALT.

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, HALT=15. Codes 12-14 are illegal and go to HALT.
- Transitions:
  - FETCH→DECODE.
  - DECODE by opcode: 100011/101011→MEMADR, 000000→EXEC, 000100→BRANCH, 000010→JUMP, 001000→ADDIEX, any other opcode→HALT.
  - MEMADR→MEMRD for lw, →MEMWR for sw. The decision uses opcode, which stays stable because the IR is held.
  - MEMRD→MEMWB.
  - EXEC→RWB.
  - ADDIEX→ADDIWB.
  - MEMWB, MEMWR, RWB, BRANCH, JUMP, ADDIWB→FETCH.
  - HALT→HALT.
- Outputs per state. Any output not listed is 0; alu_ctrl defaults to 010.
  - FETCH: mem_read, ir_write, pc_write; alu_src_b=01; pc_source=00.
  - DECODE: alu_src_b=11. This precomputes the branch target into ALUOut.
  - MEMADR: alu_src_a=1, alu_src_b=10.
  - MEMRD: mem_read, iord.
  - MEMWB: reg_write, mem_to_reg.
  - MEMWR: mem_write, iord.
  - EXEC: alu_src_a=1, alu_src_b=00, alu_ctrl decoded from funct:
    - 100000 add→010
    - 100010 sub→110
    - 100100 and→000
    - 100101 or→001
    - 101010 slt→111
    - any other funct→010
  - RWB: reg_write, reg_dst.
  - BRANCH: alu_src_a=1, alu_ctrl=110, pc_write_cond, pc_source=01.
  - JUMP: pc_write, pc_source=10.
  - ADDIEX: alu_src_a=1, alu_src_b=10.
  - ADDIWB: reg_write.
  - HALT: halted.
- instr_done is 1 in MEMWB, MEMWR, RWB, BRANCH, JUMP and ADDIWB.
- The all-zero word is an R-type with funct 000000. It executes as add into $0, which the register file discards, so it acts as a 4-cycle nop.

## Timing
- The state register updates on the rising clk edge.
- While reset is high:
  - The next state is FETCH.
  - pc_en, pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write and instr_done are forced to 0 combinationally.
  - The mux selects follow the state.
- After the edge that samples reset=1, the state is 0. The first fetch completes on the first edge with reset=0.
- Reset asserted in any state, including HALT or mid-instruction, returns to FETCH at the next edge. No memory or register write strobe is issued in that reset cycle.
- Cycles per instruction, from FETCH to return to FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- opcode is sampled only in DECODE and MEMADR. funct is used combinationally in EXEC only. zero is used combinationally in BRANCH via pc_en.
- All outputs are combinational from state, plus funct in EXEC, plus zero for pc_en, plus reset gating. There is no output register and no glitch requirement beyond settling before the next edge.

## Test plan
- Reset: hold reset for 3 cycles while in state 6, then release. Expect:
  - state=0.
  - All strobes 0 during reset.
  - FETCH strobes (mem_read=1, ir_write=1, pc_write=1, pc_en=1) high in the first non-reset cycle.
- lw: opcode=100011. Expect the state sequence 0,1,2,3,4,0; mem_read with iord=1 in state 3; reg_write=1, mem_to_reg=1, reg_dst=0 in state 4; instr_done only in state 4.
- sw, then the R-type funct sweep:
  - sw (opcode=101011): state sequence 0,1,2,5,0; mem_write=1 only in state 5.
  - R-type with funct 100000/100010/100100/100101/101010/000000: alu_ctrl in state 6 is 010/110/000/001/111/010 respectively; reg_write=1 with reg_dst=1 in state 7.
- beq, with opcode=000100:
  - zero=1: pc_en=1 in state 8.
  - zero=0: pc_en=0 in state 8.
  - In both cases the next state is 0 and pc_source=01.
- j and addi:
  - j (opcode=000010): state sequence 0,1,9,0; pc_en=1 with pc_source=10.
  - addi (opcode=001000): state sequence 0,1,10,11,0; alu_src_b=10 in state 10; reg_write=1, reg_dst=0, mem_to_reg=0 in state 11.
- Illegal opcode: opcode=111111 at DECODE. Expect state=15 and halted=1 held for 10 cycles with no strobes; reset then returns the state to 0.
